div_seq_ctrl: RTL

- Upstream divisor sequencer for the ClkDiv stage.
- Holds a small table of divisor values and drives ClkDiv's B_n input from it, one step at a time.
- Advances to the next divisor after a programmed number of out_clk rising edges; out_clk is fed back from ClkDiv.
- Both blocks run on in_clk (50 MHz system clock); used for frequency-sweep bring-up and test sequencing.

---
 rtl/div_seq_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// Divisor sequencer: steps ClkDiv's B_n through a small table, advancing after a programmed
// number of out_clk rises. Optional wrap-around mode is enabled by defining DIV_SEQ_LOOP_EN.
module div_seq_ctrl #(
   parameter int unsigned CNT_BW   = 13,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned HOLD_BW  = 8,
   parameter int unsigned IDLE_DIV = 1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic              in_clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [CNT_BW-1:0] wr_data,
   input  logic [AW:0]       num_steps,
   input  logic [HOLD_BW-1:0] hold_edges,
   input  logic              start,
   input  logic              abort,
`ifdef DIV_SEQ_LOOP_EN
   input  logic              loop,
`endif
   input  logic              out_clk,
   output logic [CNT_BW-1:0] B_n,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     step_idx
);

   localparam logic [CNT_BW-1:0] IdleDiv = CNT_BW'(IDLE_DIV);
   localparam logic [AW:0]       DepthW  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q;
   logic [CNT_BW-1:0]    tbl_q [DEPTH];
   logic                 out_clk_q;
   logic [HOLD_BW-1:0]   cnt_q;
   logic [HOLD_BW-1:0]   hold_eff_q;
   logic [AW:0]          last_q;

   logic                 rise;
   logic [HOLD_BW:0]     cnt_inc;
   logic                 cnt_hit;
   logic [AW-1:0]        idx_inc;
   logic [AW:0]          steps_eff;
   logic [HOLD_BW-1:0]   hold_eff;

   always_comb begin
      rise    = out_clk & ~out_clk_q;
      cnt_inc = {1'b0, cnt_q} + (HOLD_BW+1)'(1);
      cnt_hit = (cnt_inc == {1'b0, hold_eff_q});
      idx_inc = step_idx + AW'(1);
      if (num_steps == '0) begin
         steps_eff = (AW+1)'(1);
      end else if (num_steps > DepthW) begin
         steps_eff = DepthW;
      end else begin
         steps_eff = num_steps;
      end
      hold_eff = (hold_edges == '0) ? HOLD_BW'(1) : hold_edges;
   end

   // Table: zero divisors are promoted to 1 so ClkDiv is never handed a 0.
   always_ff @(posedge in_clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= CNT_BW'(1);
         end
      end else if (wr_en && !busy) begin
         tbl_q[wr_addr] <= (wr_data == '0) ? CNT_BW'(1) : wr_data;
      end
   end

   always_ff @(posedge in_clk) begin
      if (rst) begin
         state_q    <= StIdle;
         out_clk_q  <= 1'b0;
         cnt_q      <= '0;
         hold_eff_q <= HOLD_BW'(1);
         last_q     <= '0;
         B_n        <= IdleDiv;
         busy       <= 1'b0;
         done       <= 1'b0;
         step_idx   <= '0;
      end else begin
         out_clk_q <= out_clk;
         case (state_q)
            StIdle: begin
               B_n      <= IdleDiv;
               busy     <= 1'b0;
               done     <= 1'b0;
               step_idx <= '0;
               if (start && !abort) begin
                  state_q    <= StRun;
                  busy       <= 1'b1;
                  B_n        <= tbl_q[0];
                  cnt_q      <= '0;
                  hold_eff_q <= hold_eff;
                  last_q     <= steps_eff - (AW+1)'(1);
               end
            end
            StRun: begin
               if (abort) begin
                  state_q  <= StIdle;
                  busy     <= 1'b0;
                  B_n      <= IdleDiv;
                  step_idx <= '0;
                  cnt_q    <= '0;
               end else if (rise) begin
                  if (!cnt_hit) begin
                     cnt_q <= cnt_inc[HOLD_BW-1:0];
                  end else if ({1'b0, step_idx} != last_q) begin
                     step_idx <= idx_inc;
                     B_n      <= tbl_q[idx_inc];
                     cnt_q    <= '0;
`ifdef DIV_SEQ_LOOP_EN
                  end else if (loop) begin
                     step_idx <= '0;
                     B_n      <= tbl_q[0];
                     cnt_q    <= '0;
`endif
                  end else begin
                     // Last step complete: B_n keeps the final divisor for the DONE cycle.
                     state_q <= StDone;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q  <= StIdle;
               done     <= 1'b0;
               busy     <= 1'b0;
               B_n      <= IdleDiv;
               step_idx <= '0;
               cnt_q    <= '0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
